tmds_channel_encoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 37 +++
 rtl/tmds_qm_stage.sv | 60 ++++++
 rtl/tmds_channel_encoder.sv | 90 +++++++++
 tb/tb_tmds_channel_encoder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared constants, types and helpers for the TMDS channel encoder
//
// Contents:
//   TOKEN_00..TOKEN_11 : 10-bit control tokens sent during blanking
//   tmds_disp_t        : 5-bit signed running-disparity type (range -10..+10)
//   popcount8          : number of set bits in a byte
//   tmds_token         : maps a 2-bit control code to its token
package tmds_pkg;

    localparam logic [9:0] TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_11 = 10'b1010101011;

    typedef logic signed [4:0] tmds_disp_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] tmds_token(input logic [1:0] code);
        logic [9:0] t;
        case (code)
            2'b00:   t = TOKEN_00;
            2'b01:   t = TOKEN_01;
            2'b10:   t = TOKEN_10;
            default: t = TOKEN_11;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// rtl/tmds_qm_stage.sv - stage 1 of the TMDS encoder: transition minimisation and registers
//
// Ports:
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   de, d, c       : data enable, pixel byte, control code (from the video source)
//   qm             : registered 9-bit transition-minimised word (bit 8 = 1 means XOR path)
//   n1, n0         : registered ones/zeros count of qm[7:0]
//   de_q, c_q      : de and c delayed to line up with qm
module tmds_qm_stage
    import tmds_pkg::*;
#(
    parameter logic [1:0] CTRL_RESET = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       de,
    input  logic [7:0] d,
    input  logic [1:0] c,
    output logic [8:0] qm,
    output logic [3:0] n1,
    output logic [3:0] n0,
    output logic       de_q,
    output logic [1:0] c_q
);

    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm_next;
    logic [3:0] n1_next;

    // XNOR chaining is chosen for ones-heavy bytes so the result has fewer transitions.
    always_comb begin
        n1d      = popcount8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        qm_next    = '0;
        qm_next[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ d[i]) : (qm_next[i-1] ^ d[i]);
        end
        qm_next[8] = ~use_xnor;
        n1_next    = popcount8(qm_next[7:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qm   <= '0;
            n1   <= '0;
            n0   <= '0;
            de_q <= 1'b0;
            c_q  <= CTRL_RESET;
        end else begin
            qm   <= qm_next;
            n1   <= n1_next;
            n0   <= 4'd8 - n1_next;
            de_q <= de;
            c_q  <= c;
        end
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// rtl/tmds_channel_encoder.sv - single-channel TMDS 8b/10b encoder with running disparity
//
// Ports:
//   clk   : pixel clock, all logic on the rising edge
//   rst_n : asynchronous active-low reset
//   de    : 1 = encode d, 0 = send the control token for c
//   d     : pixel byte
//   c     : control code {c1,c0}
//   q     : 10-bit TMDS symbol, bit 0 sent first (2-cycle latency)
//   disp  : signed running disparity after q
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter logic [1:0] CTRL_RESET = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       de,
    input  logic [7:0] d,
    input  logic [1:0] c,
    output logic [9:0] q,
    output tmds_disp_t disp
);

    logic [8:0] qm;
    logic [3:0] n1;
    logic [3:0] n0;
    logic       de_q;
    logic [1:0] c_q;

    tmds_qm_stage #(
        .CTRL_RESET(CTRL_RESET)
    ) u_qm_stage (
        .clk  (clk),
        .rst_n(rst_n),
        .de   (de),
        .d    (d),
        .c    (c),
        .qm   (qm),
        .n1   (n1),
        .n0   (n0),
        .de_q (de_q),
        .c_q  (c_q)
    );

    logic [9:0] q_r;
    tmds_disp_t disp_r;
    logic [9:0] q_next;
    tmds_disp_t disp_next;
    tmds_disp_t n1_s;
    tmds_disp_t n0_s;
    tmds_disp_t diff;

    // Counts are 0..8, so a zero-extended 5-bit signed value holds them exactly.
    always_comb begin
        n1_s      = $signed({1'b0, n1});
        n0_s      = $signed({1'b0, n0});
        diff      = n1_s - n0_s;
        q_next    = tmds_token(c_q);
        disp_next = 5'sd0;
        if (de_q) begin
            if ((disp_r == 5'sd0) || (n1 == n0)) begin
                // Balanced word or no history: pick inversion from qm[8] alone.
                q_next    = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                disp_next = disp_r + (qm[8] ? diff : -diff);
            end else if (((disp_r > 5'sd0) && (n1 > n0)) || ((disp_r < 5'sd0) && (n0 > n1))) begin
                // Word would push disparity further the same way: invert it.
                q_next    = {1'b1, qm[8], ~qm[7:0]};
                disp_next = disp_r + (qm[8] ? 5'sd2 : 5'sd0) - diff;
            end else begin
                q_next    = {1'b0, qm[8], qm[7:0]};
                disp_next = disp_r + diff - (qm[8] ? 5'sd0 : 5'sd2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r    <= tmds_token(CTRL_RESET);
            disp_r <= 5'sd0;
        end else begin
            q_r    <= q_next;
            disp_r <= disp_next;
        end
    end

    assign q    = q_r;
    assign disp = disp_r;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb/tb_tmds_channel_encoder.sv - scoreboard bench for tmds_channel_encoder with directed vectors
module tb_tmds_channel_encoder;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              de    = 1'b0;
    logic [7:0]        d     = 8'h00;
    logic [1:0]        c     = 2'b00;
    logic [9:0]        q;
    logic signed [4:0] disp;

    tmds_channel_encoder dut (
        .clk  (clk),
        .rst_n(rst_n),
        .de   (de),
        .d    (d),
        .c    (c),
        .q    (q),
        .disp (disp)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        int         id;
        logic [9:0] q;
        int         disp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_now(input int id, input logic [9:0] eq, input int ed);
        checks++;
        if ((q !== eq) || (int'(disp) != ed)) begin
            errors++;
            $display("FAIL vec%0d: got q=%h disp=%0d, required q=%h disp=%0d",
                     id, q, disp, eq, ed);
        end
    endtask

    // Monitor: one symbol per cycle, compared when its due cycle comes up.
    always @(posedge clk) begin : monitor
        exp_t e;
        #3;
        while ((sb.size() > 0) && (sb[0].due <= cyc)) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL vec%0d: missed due cycle %0d (now %0d)", e.id, e.due, cyc);
            end else begin
                check_now(e.id, e.q, e.disp);
            end
        end
    end

    task automatic drive(input logic de_i, input logic [7:0] d_i, input logic [1:0] c_i,
                         input int id, input logic [9:0] eq, input int ed);
        exp_t e;
        de = de_i;
        d  = d_i;
        c  = c_i;
        e.due  = cyc + 2;
        e.id   = id;
        e.q    = eq;
        e.disp = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reset-token symbol produced by stage-1 reset contents one edge after release.
    task automatic expect_reset_token(input int id);
        exp_t e;
        e.due  = cyc + 1;
        e.id   = id;
        e.q    = 10'h354;
        e.disp = 0;
        sb.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_now(0, 10'h354, 0);

        rst_n = 1'b1;
        expect_reset_token(100);
        drive(1'b1, 8'h00, 2'b11,  1, 10'h100, -8);
        drive(1'b1, 8'h00, 2'b11,  2, 10'h3FF,  2);
        drive(1'b0, 8'hFF, 2'b00,  3, 10'h354,  0);
        drive(1'b1, 8'hFF, 2'b01,  4, 10'h200, -8);
        drive(1'b0, 8'h00, 2'b00,  5, 10'h354,  0);
        drive(1'b0, 8'h00, 2'b01,  6, 10'h0AB,  0);
        drive(1'b0, 8'h00, 2'b10,  7, 10'h154,  0);
        drive(1'b0, 8'h00, 2'b11,  8, 10'h2AB,  0);
        drive(1'b1, 8'h00, 2'b00,  9, 10'h100, -8);
        drive(1'b1, 8'hFF, 2'b00, 10, 10'h0FF, -2);
        drive(1'b1, 8'h0F, 2'b10, 11, 10'h3FA,  4);
        drive(1'b1, 8'h10, 2'b00, 12, 10'h1F0,  4);
        drive(1'b1, 8'h00, 2'b00, 13, 10'h100, -4);
        drive(1'b1, 8'hFF, 2'b00, 14, 10'h0FF,  2);
        drive(1'b1, 8'hFF, 2'b00, 15, 10'h200, -6);
        drive(1'b1, 8'h1E, 2'b00, 16, 10'h25F, -2);
        drive(1'b1, 8'h00, 2'b00, 17, 10'h3FF,  8);

        // Mid-stream reset: d=FF is in flight and must be discarded.
        de = 1'b1;
        d  = 8'hFF;
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_now(200, 10'h354, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_reset_token(101);
        drive(1'b1, 8'h00, 2'b00, 18, 10'h100, -8);
        drive(1'b0, 8'h00, 2'b10, 19, 10'h154,  0);
        de = 1'b0;
        c  = 2'b00;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #5;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected symbols never checked, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
